// File: rtl/lottery_checker_param.sv
// Positional lottery ticket checker: compares digits against a fixed winning
// number, grades the ticket into a prize tier and counts winners per tier.
module lottery_checker_param #(
  parameter int N_DIGITS = 5,
  parameter int DIGIT_W = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] WIN_NUM = 20'h47019,
  parameter int N_TIERS = 2,
  parameter int CNT_W = 5,
  localparam int PRZ_W = $clog2(N_TIERS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       game_end,
  input  logic                       digit_valid,
  input  logic [DIGIT_W-1:0]         digit,
  input  logic                       ticket_end,
  output logic [PRZ_W-1:0]           prize,
  output logic                       prize_valid,
  output logic                       ticket_err,
  output logic                       busy,
  output logic [N_TIERS*CNT_W-1:0]   prize_cnt,
  output logic [N_TIERS-1:0]         cnt_sat
);

  localparam int POS_W = $clog2(N_DIGITS + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_DIGITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   match_q, match_d;
  logic               ovf_q, ovf_d;
  logic [PRZ_W-1:0]   prize_q, prize_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q [N_TIERS];

  logic [DIGIT_W-1:0] win_dig_s [2**POS_W];
  logic [POS_W-1:0]   acc_pos_s;
  logic [POS_W-1:0]   acc_match_s;
  logic               acc_ovf_s;
  logic               eval_err_s;
  logic [PRZ_W-1:0]   eval_prize_s;
  int                 tier_s;
  logic               cnt_inc_s;

  // Winning digits indexed by entry position; the MS digit is entered first.
  for (genvar g = 0; g < 2**POS_W; g++) begin : g_win
    if (g < N_DIGITS) begin : g_real
      assign win_dig_s[g] = WIN_NUM[(N_DIGITS-1-g)*DIGIT_W +: DIGIT_W];
    end else begin : g_pad
      assign win_dig_s[g] = '0;
    end
  end

  // Position/match/overflow after accepting this cycle's digit, so a digit
  // arriving together with ticket_end is graded as part of the ticket.
  always_comb begin
    acc_pos_s   = pos_q;
    acc_match_s = match_q;
    acc_ovf_s   = ovf_q;
    if (digit_valid && (state_q != EVAL)) begin
      if (pos_q == POS_MAX) begin
        acc_ovf_s = 1'b1;
      end else begin
        if (digit == win_dig_s[pos_q]) begin
          acc_match_s = match_q + POS_W'(1);
        end else begin
          acc_match_s = match_q;
        end
        acc_pos_s = pos_q + POS_W'(1);
      end
    end else begin
      acc_ovf_s = ovf_q;
    end
  end

  // Grade the accumulated ticket: tier = N_DIGITS - matches + 1 when in range.
  always_comb begin
    eval_err_s   = (acc_pos_s != POS_MAX) || acc_ovf_s;
    tier_s       = N_DIGITS - int'(acc_match_s) + 1;
    eval_prize_s = '0;
    if (!eval_err_s && (tier_s <= N_TIERS)) begin
      eval_prize_s = PRZ_W'(tier_s);
    end else begin
      eval_prize_s = '0;
    end
  end

  // Next-state logic; game_end outranks ticket_end and digit_valid everywhere.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    match_d   = match_q;
    ovf_d     = ovf_q;
    prize_d   = prize_q;
    err_d     = err_q;
    cnt_inc_s = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (game_end) begin
          state_d = IDLE;
          pos_d   = '0;
          match_d = '0;
          ovf_d   = 1'b0;
          prize_d = '0;
          err_d   = 1'b0;
        end else if (ticket_end) begin
          state_d = EVAL;
          pos_d   = acc_pos_s;
          match_d = acc_match_s;
          ovf_d   = acc_ovf_s;
          prize_d = eval_prize_s;
          err_d   = eval_err_s;
        end else if (digit_valid) begin
          state_d = COLLECT;
          pos_d   = acc_pos_s;
          match_d = acc_match_s;
          ovf_d   = acc_ovf_s;
          if (state_q == IDLE) begin
            prize_d = '0;
            err_d   = 1'b0;
          end else begin
            prize_d = prize_q;
            err_d   = err_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      EVAL: begin
        state_d = IDLE;
        pos_d   = '0;
        match_d = '0;
        ovf_d   = 1'b0;
        if (game_end) begin
          prize_d = '0;
          err_d   = 1'b0;
        end else begin
          cnt_inc_s = !err_q && (prize_q != '0);
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = '0;
        match_d = '0;
        ovf_d   = 1'b0;
        prize_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Ticket state and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      match_q <= '0;
      ovf_q   <= 1'b0;
      prize_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      prize_q <= prize_d;
      err_q   <= err_d;
    end
  end

  // Per-tier saturating winner counters, committed as EVAL completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_TIERS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_TIERS; k++) begin
        if (cnt_inc_s && (prize_q == PRZ_W'(k + 1)) && (cnt_q[k] != {CNT_W{1'b1}})) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end else begin
          cnt_q[k] <= cnt_q[k];
        end
      end
    end
  end

  for (genvar g = 0; g < N_TIERS; g++) begin : g_cnt
    assign prize_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    assign cnt_sat[g]                  = &cnt_q[g];
  end

  // A game_end arriving during EVAL cancels the report in that same cycle.
  assign prize_valid = (state_q == EVAL) && !game_end;
  assign prize       = prize_q;
  assign ticket_err  = err_q;
  assign busy        = (state_q == COLLECT);

endmodule

// File: tb/tb_lottery_checker_param.sv
// Scoreboard bench for lottery_checker_param: default 5-digit build plus a
// 6-digit/8-bit/3-tier build graded with directed tickets.
module tb_lottery_checker_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic game_end = 1'b0;

  logic       dv_a = 1'b0, te_a = 1'b0;
  logic [3:0] dig_a = 4'd0;
  logic [1:0] prize_a;
  logic       pv_a, err_a, busy_a;
  logic [9:0] cnt_a;
  logic [1:0] sat_a;

  logic       dv_b = 1'b0, te_b = 1'b0;
  logic [7:0] dig_b = 8'd0;
  logic [1:0] prize_b;
  logic       pv_b, err_b, busy_b;
  logic [11:0] cnt_b;
  logic [2:0] sat_b;

  typedef struct { logic [1:0] prize; logic err; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  logic [4:0] ma [2];
  logic [3:0] mb [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lottery_checker_param dut_a (
    .clk(clk), .reset(reset), .game_end(game_end),
    .digit_valid(dv_a), .digit(dig_a), .ticket_end(te_a),
    .prize(prize_a), .prize_valid(pv_a), .ticket_err(err_a), .busy(busy_a),
    .prize_cnt(cnt_a), .cnt_sat(sat_a)
  );

  lottery_checker_param #(
    .N_DIGITS(6), .DIGIT_W(8), .WIN_NUM(48'hA1B2C3D4E5F6), .N_TIERS(3), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .game_end(game_end),
    .digit_valid(dv_b), .digit(dig_b), .ticket_end(te_b),
    .prize(prize_b), .prize_valid(pv_b), .ticket_err(err_b), .busy(busy_b),
    .prize_cnt(cnt_b), .cnt_sat(sat_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the default build.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (pv_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_prize_valid", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_prize", {30'd0, prize_a}, {30'd0, e.prize});
        chk("a_ticket_err", {31'd0, err_a}, {31'd0, e.err});
      end
    end
  end

  // Scoreboard monitor for the wide build.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (pv_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_prize_valid", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_prize", {30'd0, prize_b}, {30'd0, e.prize});
        chk("b_ticket_err", {31'd0, err_b}, {31'd0, e.err});
      end
    end
  end

  task automatic a_ticket(input logic [23:0] v, input int n, input bit same,
                          input logic [1:0] ep, input logic ee);
    exp_t e;
    e.prize = ep;
    e.err = ee;
    for (int i = 0; i < n; i++) begin
      dv_a = 1'b1;
      dig_a = v[(n-1-i)*4 +: 4];
      if (same && (i == n - 1)) begin
        qa.push_back(e);
        te_a = 1'b1;
      end
      step();
    end
    dv_a = 1'b0;
    if (!same || n == 0) begin
      qa.push_back(e);
      te_a = 1'b1;
      step();
    end
    te_a = 1'b0;
    chk("a_valid_latency", {31'd0, pv_a}, 32'd1);
    step();
    if (!ee && ep != 2'd0) begin
      if (ma[ep-1] != 5'd31) ma[ep-1] = ma[ep-1] + 5'd1;
    end
  endtask

  task automatic b_ticket(input logic [47:0] v, input logic [1:0] ep);
    exp_t e;
    e.prize = ep;
    e.err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dv_b = 1'b1;
      dig_b = v[(5-i)*8 +: 8];
      step();
    end
    dv_b = 1'b0;
    qb.push_back(e);
    te_b = 1'b1;
    step();
    te_b = 1'b0;
    step();
    if (ep != 2'd0) begin
      if (mb[ep-1] != 4'd15) mb[ep-1] = mb[ep-1] + 4'd1;
    end
  endtask

  task automatic chk_cnt_a();
    chk("a_tier1_cnt", {27'd0, cnt_a[4:0]}, {27'd0, ma[0]});
    chk("a_tier2_cnt", {27'd0, cnt_a[9:5]}, {27'd0, ma[1]});
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_prize"}, {30'd0, prize_a}, 32'd0);
    chk({tag, "_valid"}, {31'd0, pv_a}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_a}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_cnt"}, {22'd0, cnt_a}, 32'd0);
    chk({tag, "_sat"}, {30'd0, sat_a}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ma[0] = 5'd0; ma[1] = 5'd0;
    mb[0] = 4'd0; mb[1] = 4'd0; mb[2] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    reset = 1'b0;
    step();

    // T1 / T2: full match, 4 matches, 3 matches
    a_ticket(24'h047019, 5, 1'b0, 2'd1, 1'b0);
    chk_cnt_a();
    a_ticket(24'h047013, 5, 1'b0, 2'd2, 1'b0);
    chk_cnt_a();
    a_ticket(24'h047513, 5, 1'b0, 2'd0, 1'b0);
    chk_cnt_a();

    // T3: short, long and empty tickets
    a_ticket(24'h000470, 3, 1'b0, 2'd0, 1'b1);
    step();
    chk("a_err_holds", {31'd0, err_a}, 32'd1);
    a_ticket(24'h470191, 6, 1'b0, 2'd0, 1'b1);
    a_ticket(24'h000000, 0, 1'b0, 2'd0, 1'b1);
    chk_cnt_a();

    // First digit clears the held error; game_end aborts silently
    dv_a = 1'b1; dig_a = 4'd4; step();
    chk("a_err_cleared_by_digit", {31'd0, err_a}, 32'd0);
    chk("a_busy_collect", {31'd0, busy_a}, 32'd1);
    dig_a = 4'd7; step();
    dv_a = 1'b0; game_end = 1'b1; step();
    game_end = 1'b0;
    chk("a_busy_after_game_end", {31'd0, busy_a}, 32'd0);
    step();

    // T4: last digit and ticket_end together
    a_ticket(24'h047019, 5, 1'b1, 2'd1, 1'b0);
    chk_cnt_a();
    chk("a_prize_holds", {30'd0, prize_a}, 32'd1);

    // game_end during EVAL: no report, no count, result cleared
    for (int i = 0; i < 5; i++) begin
      dv_a = 1'b1;
      case (i)
        0: dig_a = 4'h4;
        1: dig_a = 4'h7;
        2: dig_a = 4'h0;
        3: dig_a = 4'h1;
        default: dig_a = 4'h9;
      endcase
      step();
    end
    dv_a = 1'b0; te_a = 1'b1; step();
    te_a = 1'b0; game_end = 1'b1; step();
    game_end = 1'b0; step();
    chk_cnt_a();
    chk("a_prize_after_eval_abort", {30'd0, prize_a}, 32'd0);

    // T5: tier-1 counter saturates at 31
    for (int i = 0; i < 30; i++) begin
      a_ticket(24'h047019, 5, 1'b0, 2'd1, 1'b0);
    end
    chk_cnt_a();
    chk("a_tier1_sat_value", {27'd0, cnt_a[4:0]}, 32'd31);
    chk("a_cnt_sat", {30'd0, sat_a}, 32'd1);

    reset = 1'b1; #3;
    chk_idle_zero("mid_reset");
    ma[0] = 5'd0; ma[1] = 5'd0;
    step();
    reset = 1'b0;
    step();

    // T6: 6-digit, 8-bit, 3-tier build
    b_ticket(48'hA1B2C3D40000, 2'd3);
    b_ticket(48'hA1B2C3D4E5F6, 2'd1);
    b_ticket(48'hA1B2C3D4E500, 2'd2);
    b_ticket(48'h00B2C3000000, 2'd0);
    chk("b_tier1_cnt", {28'd0, cnt_b[3:0]}, {28'd0, mb[0]});
    chk("b_tier2_cnt", {28'd0, cnt_b[7:4]}, {28'd0, mb[1]});
    chk("b_tier3_cnt", {28'd0, cnt_b[11:8]}, {28'd0, mb[2]});

    repeat (3) step();
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
